// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings,
// supported operand widths and the shift-amount width helper.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } shift_mode_e;

    localparam int XLEN_MIN = 32;
    localparam int XLEN_MAX = 64;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_MIN) || (xlen == XLEN_MAX);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage: applies barrel levels LO..LO+NLEV-1 to the incoming
// operand and registers the partial result with its sideband state.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int LO    = 0,
    parameter int NLEV  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      adv_i,
    input  logic                      valid_i,
    input  logic [XLEN-1:0]           data_i,
    input  logic [$clog2(XLEN)-1:0]   shamt_i,
    input  logic [2:0]                mode_i,
    input  logic [TAG_W-1:0]          tag_i,
    output logic                      valid_o,
    output logic [XLEN-1:0]           data_o,
    output logic [$clog2(XLEN)-1:0]   shamt_o,
    output logic [2:0]                mode_o,
    output logic [TAG_W-1:0]          tag_o
);

    function automatic logic [XLEN-1:0] level_shift(input logic [XLEN-1:0] d,
                                                    input logic [2:0]      mode,
                                                    input int              amt);
        logic [XLEN-1:0] r;
        case (mode)
            MODE_SLL: r = d << amt;
            MODE_SRL: r = d >> amt;
            MODE_SRA: r = $signed(d) >>> amt;
            MODE_ROL: r = (d << amt) | (d >> (XLEN - amt));
            MODE_ROR: r = (d >> amt) | (d << (XLEN - amt));
            default:  r = d;
        endcase
        return r;
    endfunction

    // A stage may own zero levels when the level count does not divide evenly.
    logic [XLEN-1:0] lvl [NLEV+1];
    assign lvl[0] = data_i;

    genvar gi;
    for (gi = 0; gi < NLEV; gi++) begin : g_level
        localparam int K = LO + gi;
        assign lvl[gi+1] = shamt_i[K] ? level_shift(lvl[gi], mode_i, 1 << K) : lvl[gi];
    end

    logic                    valid_q;
    logic [XLEN-1:0]         data_q;
    logic [XLEN-1:0]         data_d;
    logic [$clog2(XLEN)-1:0] shamt_q;
    logic [2:0]              mode_q;
    logic [TAG_W-1:0]        tag_q;

    assign data_d = lvl[NLEV];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                mode_q  <= mode_i;
                tag_q   <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Log2 barrel shifter split over STAGES registered stages with a
// valid/ready handshake, flush, and back-pressure that ripples stage to stage.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [XLEN-1:0]           in_data,
    input  logic [$clog2(XLEN)-1:0]   in_shamt,
    input  logic [2:0]                in_mode,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_data,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int SW  = shamt_width(XLEN);
    localparam int LPS = (SW + STAGES - 1) / STAGES;

    // Index 0 is the input port bundle; index s+1 is the register of stage s.
    logic             st_valid [STAGES+1];
    logic [XLEN-1:0]  st_data  [STAGES+1];
    logic [SW-1:0]    st_shamt [STAGES+1];
    logic [2:0]       st_mode  [STAGES+1];
    logic [TAG_W-1:0] st_tag   [STAGES+1];
    logic             adv      [STAGES];

    always_comb begin
        adv[STAGES-1] = !st_valid[STAGES] || out_ready;
        for (int s = STAGES - 2; s >= 0; s--) begin
            adv[s] = !st_valid[s+1] || adv[s+1];
        end
    end

    assign in_ready    = adv[0] && !flush;
    assign st_valid[0] = in_valid && in_ready;
    assign st_data[0]  = in_data;
    assign st_shamt[0] = in_shamt;
    assign st_mode[0]  = in_mode;
    assign st_tag[0]   = in_tag;

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO   = gi * LPS;
        localparam int HI   = ((gi + 1) * LPS < SW) ? (gi + 1) * LPS : SW;
        localparam int NLEV = (HI > LO) ? HI - LO : 0;

        shift_stage #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .LO    (LO),
            .NLEV  (NLEV)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .adv_i   (adv[gi]),
            .valid_i (st_valid[gi]),
            .data_i  (st_data[gi]),
            .shamt_i (st_shamt[gi]),
            .mode_i  (st_mode[gi]),
            .tag_i   (st_tag[gi]),
            .valid_o (st_valid[gi+1]),
            .data_o  (st_data[gi+1]),
            .shamt_o (st_shamt[gi+1]),
            .mode_o  (st_mode[gi+1]),
            .tag_o   (st_tag[gi+1])
        );
    end

    assign out_valid = st_valid[STAGES];
    assign out_data  = st_data[STAGES];
    assign out_tag   = st_tag[STAGES];

    // Shift amount and mode are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{st_shamt[STAGES], st_mode[STAGES]};

endmodule
